// File: rtl/dmux_route_ctrl.sv
// Two-way word steering controller with directed, alternating and burst routing.
// Per-destination output registers with pass-through and saturating word counters.
module dmux_route_ctrl #(
  parameter int DATA_W    = 24,
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        cfg_mode,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sel,
  output logic              in_ready,
  output logic              a_valid,
  output logic [DATA_W-1:0] a_data,
  input  logic              a_ready,
  output logic              b_valid,
  output logic [DATA_W-1:0] b_data,
  input  logic              b_ready,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  cnt_a,
  output logic [CNT_W-1:0]  cnt_b,
  output logic              cur_dest
);

  typedef enum logic {
    PT_A = 1'b0,
    PT_B = 1'b1
  } ptr_e;

  localparam logic [7:0] BLAST = 8'(BURST_LEN - 1);

  ptr_e       ptr;
  logic [1:0] mode_q;
  logic [7:0] bcnt;

  logic tgt;
  logic tgt_valid;
  logic tgt_ready;
  logic mode_chg;
  logic accept;
  logic acc_a;
  logic acc_b;

  always_comb begin
    tgt = 1'b0;
    unique case (mode_q)
      2'b00:   tgt = in_sel;
      2'b01,
      2'b10:   tgt = (ptr == PT_B);
      default: tgt = 1'b0;
    endcase
  end

  assign tgt_valid = tgt ? b_valid : a_valid;
  assign tgt_ready = tgt ? b_ready : a_ready;
  assign mode_chg  = (cfg_mode != mode_q);

  // A draining target can take the next word in the same cycle.
  assign in_ready = !reset
                 && (mode_q != 2'b11)
                 && !mode_chg
                 && (!tgt_valid || tgt_ready);

  assign accept = in_valid && in_ready;
  assign acc_a  = accept && !tgt;
  assign acc_b  = accept && tgt;

  assign cur_dest = (ptr == PT_B);

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr    <= PT_A;
      bcnt   <= '0;
      mode_q <= 2'b00;
    end else begin
      mode_q <= cfg_mode;
      if (mode_chg) begin
        ptr  <= PT_A;
        bcnt <= '0;
      end else if (accept) begin
        unique case (mode_q)
          2'b01: ptr <= (ptr == PT_A) ? PT_B : PT_A;
          2'b10: begin
            if (bcnt == BLAST) begin
              ptr  <= (ptr == PT_A) ? PT_B : PT_A;
              bcnt <= '0;
            end else begin
              bcnt <= bcnt + 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_valid <= 1'b0;
      a_data  <= '0;
    end else if (acc_a) begin
      a_valid <= 1'b1;
      a_data  <= in_data;
    end else if (a_ready) begin
      a_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      b_valid <= 1'b0;
      b_data  <= '0;
    end else if (acc_b) begin
      b_valid <= 1'b1;
      b_data  <= in_data;
    end else if (b_ready) begin
      b_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else if (cnt_clr) begin
      cnt_a <= acc_a ? CNT_W'(1) : '0;
      cnt_b <= acc_b ? CNT_W'(1) : '0;
    end else begin
      if (acc_a && (cnt_a != '1))
        cnt_a <= cnt_a + CNT_W'(1);
      if (acc_b && (cnt_b != '1))
        cnt_b <= cnt_b + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_dmux_route_ctrl.sv
// Bench for dmux_route_ctrl: vector table, directed corner sequences and
// random traffic against an accept-count based reference model.
module tb_dmux_route_ctrl;

  localparam int DW = 24;
  localparam int BL = 4;
  localparam int CW = 16;
  localparam int CMAX = 65535;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    cfg_mode;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_sel;
  logic          in_ready;
  logic          a_valid;
  logic [DW-1:0] a_data;
  logic          a_ready;
  logic          b_valid;
  logic [DW-1:0] b_data;
  logic          b_ready;
  logic          cnt_clr;
  logic [CW-1:0] cnt_a;
  logic [CW-1:0] cnt_b;
  logic          cur_dest;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  dmux_route_ctrl #(.DATA_W(DW), .BURST_LEN(BL), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .cfg_mode(cfg_mode),
    .in_valid(in_valid), .in_data(in_data), .in_sel(in_sel),
    .in_ready(in_ready),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .cnt_clr(cnt_clr), .cnt_a(cnt_a), .cnt_b(cnt_b),
    .cur_dest(cur_dest)
  );

  // Reference model: routing derived from number of accepts since mode entry.
  int            m_mq;
  int            m_nacc;
  bit            m_v[2];
  logic [DW-1:0] m_d[2];
  int            m_c[2];

  task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      if (failed <= 30)
        $display("FAIL %s: got %h expected %h at %0t", n, got, exp, $time);
    end
  endtask

  function automatic int m_ptr();
    if (m_mq == 1) return m_nacc % 2;
    if (m_mq == 2) return (m_nacc / BL) % 2;
    return 0;
  endfunction

  function automatic int m_tgt();
    if (m_mq == 0) return int'(in_sel);
    return m_ptr();
  endfunction

  function automatic bit m_ir();
    int t;
    bit rd;
    t  = m_tgt();
    rd = (t == 1) ? b_ready : a_ready;
    return !reset && m_mq != 3 && int'(cfg_mode) == m_mq
        && (!m_v[t] || rd);
  endfunction

  task automatic tick();
    bit ir;
    bit acc;
    int t;
    bit rdy[2];
    #1;
    ir  = m_ir();
    t   = m_tgt();
    acc = in_valid && ir;
    rdy[0] = a_ready;
    rdy[1] = b_ready;
    chk("in_ready", in_ready, ir);
    @(posedge clk);
    if (reset) begin
      m_mq = 0; m_nacc = 0;
      for (int d = 0; d < 2; d++) begin
        m_v[d] = 0; m_d[d] = '0; m_c[d] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (acc && t == d) begin
          m_v[d] = 1; m_d[d] = in_data;
        end else if (rdy[d]) begin
          m_v[d] = 0;
        end
      end
      if (cnt_clr) begin
        m_c[0] = 0; m_c[1] = 0;
      end
      if (acc && m_c[t] < CMAX) m_c[t]++;
      if (int'(cfg_mode) != m_mq) m_nacc = 0;
      else if (acc && (m_mq == 1 || m_mq == 2)) m_nacc++;
      m_mq = int'(cfg_mode);
    end
    #1;
    chk("a_valid", a_valid, m_v[0]);
    chk("a_data", a_data, m_d[0]);
    chk("b_valid", b_valid, m_v[1]);
    chk("b_data", b_data, m_d[1]);
    chk("cnt_a", cnt_a, m_c[0]);
    chk("cnt_b", cnt_b, m_c[1]);
    chk("cur_dest", cur_dest, m_ptr());
    @(negedge clk);
  endtask

  task automatic drive(logic [1:0] m, logic v, logic [DW-1:0] d,
                       logic s, logic ar, logic br, logic c);
    cfg_mode = m; in_valid = v; in_data = d;
    in_sel = s; a_ready = ar; b_ready = br; cnt_clr = c;
  endtask

  typedef struct {
    logic [1:0]    mode;
    logic          v;
    logic [DW-1:0] d;
    logic          sel;
    logic          ar;
    logic          br;
    logic          e_ir;
    logic          e_av;
    logic [DW-1:0] e_ad;
    logic          e_bv;
    logic [DW-1:0] e_bd;
    logic          e_cd;
  } vec_t;

  vec_t tbl[14];
  int   exp_dst[10];

  initial begin
    // mode 01 alternation
    tbl[0]  = '{2'b01, 0, 24'h0,      0, 1, 1, 0, 0, 24'h0,      0, 24'h0, 0};
    tbl[1]  = '{2'b01, 1, 24'h1,      0, 1, 1, 1, 1, 24'h1,      0, 24'h0, 1};
    tbl[2]  = '{2'b01, 1, 24'h2,      0, 1, 1, 1, 0, 24'h1,      1, 24'h2, 0};
    tbl[3]  = '{2'b01, 1, 24'h3,      0, 1, 1, 1, 1, 24'h3,      0, 24'h2, 1};
    tbl[4]  = '{2'b01, 1, 24'h4,      0, 1, 1, 1, 0, 24'h3,      1, 24'h4, 0};
    tbl[5]  = '{2'b01, 1, 24'h5,      0, 1, 1, 1, 1, 24'h5,      0, 24'h4, 1};
    tbl[6]  = '{2'b01, 1, 24'h6,      0, 1, 1, 1, 0, 24'h5,      1, 24'h6, 0};
    tbl[7]  = '{2'b01, 0, 24'h0,      0, 1, 1, 1, 0, 24'h5,      0, 24'h6, 0};
    // mode 00 stall on A then pass-through
    tbl[8]  = '{2'b00, 0, 24'h0,      0, 1, 1, 0, 0, 24'h5,      0, 24'h6, 0};
    tbl[9]  = '{2'b00, 1, 24'hABCDEF, 0, 0, 1, 1, 1, 24'hABCDEF, 0, 24'h6, 0};
    tbl[10] = '{2'b00, 1, 24'h123456, 0, 0, 1, 0, 1, 24'hABCDEF, 0, 24'h6, 0};
    tbl[11] = '{2'b00, 1, 24'h123456, 0, 0, 1, 0, 1, 24'hABCDEF, 0, 24'h6, 0};
    tbl[12] = '{2'b00, 1, 24'h123456, 0, 1, 1, 1, 1, 24'h123456, 0, 24'h6, 0};
    tbl[13] = '{2'b00, 0, 24'h0,      0, 1, 1, 1, 0, 24'h123456, 0, 24'h6, 0};
    exp_dst = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};

    m_mq = 0; m_nacc = 0;
    for (int d = 0; d < 2; d++) begin
      m_v[d] = 0; m_d[d] = '0; m_c[d] = 0;
    end

    reset = 1'b1;
    drive(2'b00, 0, '0, 0, 1, 1, 0);
    @(negedge clk);
    tick();
    tick();
    reset = 1'b0;
    chk("rst_a_valid", a_valid, 0);
    chk("rst_cnt_a", cnt_a, 0);

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].mode, tbl[i].v, tbl[i].d, tbl[i].sel,
            tbl[i].ar, tbl[i].br, 0);
      #1 chk($sformatf("tbl%0d_ir", i), in_ready, tbl[i].e_ir);
      tick();
      chk($sformatf("tbl%0d_av", i), a_valid, tbl[i].e_av);
      chk($sformatf("tbl%0d_ad", i), a_data, tbl[i].e_ad);
      chk($sformatf("tbl%0d_bv", i), b_valid, tbl[i].e_bv);
      chk($sformatf("tbl%0d_bd", i), b_data, tbl[i].e_bd);
      chk($sformatf("tbl%0d_cd", i), cur_dest, tbl[i].e_cd);
      if (i == 7) begin
        chk("alt_cnt_a", cnt_a, 3);
        chk("alt_cnt_b", cnt_b, 3);
      end
    end

    // burst routing, ten words
    drive(2'b10, 0, '0, 0, 1, 1, 0);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(2'b10, 1, DW'(24'h100 + i), 0, 1, 1, 0);
      tick();
      if (exp_dst[i] == 0) begin
        chk($sformatf("burst%0d_av", i), a_valid, 1);
        chk($sformatf("burst%0d_ad", i), a_data, 24'h100 + i);
      end else begin
        chk($sformatf("burst%0d_bv", i), b_valid, 1);
        chk($sformatf("burst%0d_bd", i), b_data, 24'h100 + i);
      end
    end
    chk("burst_cur_dest", cur_dest, 0);

    // mode switch 01 -> 10 with pointer on B
    drive(2'b01, 0, '0, 0, 1, 1, 0);
    tick();
    drive(2'b01, 1, 24'h200, 0, 1, 1, 0);
    tick();
    chk("sw_ptr_b", cur_dest, 1);
    drive(2'b10, 1, 24'h201, 0, 1, 1, 0);
    #1 chk("sw_ir_low", in_ready, 0);
    tick();
    chk("sw_ptr_a", cur_dest, 0);
    #1 chk("sw_ir_high", in_ready, 1);
    tick();
    chk("sw_a_valid", a_valid, 1);
    chk("sw_a_data", a_data, 24'h201);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      reset    = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 29) == 0) cfg_mode = 2'($urandom_range(0, 3));
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = DW'($urandom);
      in_sel   = 1'($urandom_range(0, 1));
      a_ready  = ($urandom_range(0, 9) < 7);
      b_ready  = ($urandom_range(0, 9) < 7);
      cnt_clr  = ($urandom_range(0, 49) == 0);
      tick();
    end
    reset = 1'b0;

    // counter saturation
    drive(2'b00, 0, '0, 0, 1, 1, 1);
    tick();
    drive(2'b00, 0, '0, 0, 1, 1, 0);
    tick();
    drive(2'b00, 1, 24'h5A5A5A, 0, 1, 1, 0);
    for (int i = 0; i < CMAX; i++) tick();
    chk("sat_full", cnt_a, 16'hFFFF);
    tick();
    chk("sat_hold", cnt_a, 16'hFFFF);
    drive(2'b00, 1, 24'h777777, 0, 1, 1, 1);
    tick();
    chk("clr_acc_a", cnt_a, 1);
    chk("clr_acc_b", cnt_b, 0);

    // reset with both outputs full and counters at 7
    drive(2'b00, 0, '0, 0, 1, 1, 1);
    tick();
    for (int i = 0; i < 12; i++) begin
      drive(2'b00, 1, DW'(24'h300 + i), 1'(i % 2), 1, 1, 0);
      tick();
    end
    drive(2'b00, 0, '0, 0, 1, 1, 0);
    tick();
    drive(2'b00, 1, 24'h400, 0, 0, 0, 0);
    tick();
    drive(2'b00, 1, 24'h401, 1, 0, 0, 0);
    tick();
    chk("pre_rst_cnt_a", cnt_a, 7);
    chk("pre_rst_cnt_b", cnt_b, 7);
    chk("pre_rst_av", a_valid, 1);
    chk("pre_rst_bv", b_valid, 1);
    reset = 1'b1;
    drive(2'b01, 1, 24'h402, 1, 0, 0, 0);
    #1 chk("rst_ir", in_ready, 0);
    tick();
    chk("rst2_av", a_valid, 0);
    chk("rst2_bv", b_valid, 0);
    chk("rst2_cnt_a", cnt_a, 0);
    chk("rst2_cnt_b", cnt_b, 0);
    chk("rst2_cd", cur_dest, 0);
    reset = 1'b0;
    drive(2'b00, 0, '0, 0, 1, 1, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/dmux_route_ctrl.md
Name: dmux_route_ctrl

Overview:
- Steering controller that sequences a 24-bit word stream from one producer to two consumers, A and B, with valid/ready handshakes.
- Replaces a free-running select line with a decided routing policy: directed, alternating, or fixed-length bursts.
- Provides registered, per-destination output buffering and saturating word counters.
- Sits between the instruction/data fetch path and the two downstream execution/storage consumers.

Parameters:
- DATA_W, 24, data word width
- BURST_LEN, 4, words sent per destination in burst mode (range 1..255)
- CNT_W, 16, width of the per-destination word counters

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- cfg_mode  in  2  routing policy: 00 directed, 01 alternate, 10 burst, 11 hold
- in_valid  in  1  producer word valid
- in_data  in  DATA_W  producer word
- in_sel  in  1  destination in directed mode (0 = A, 1 = B); ignored in other modes
- in_ready  out  1  controller accepts in_data this cycle
- a_valid  out  1  output A word valid
- a_data  out  DATA_W  output A word
- a_ready  in  1  consumer A accepts
- b_valid  out  1  output B word valid
- b_data  out  DATA_W  output B word
- b_ready  in  1  consumer B accepts
- cnt_clr  in  1  clear both word counters
- cnt_a  out  CNT_W  words accepted for A, saturating
- cnt_b  out  CNT_W  words accepted for B, saturating
- cur_dest  out  1  current target pointer (0 = A, 1 = B)

Behaviour:
- Reset (synchronous, wins over all other inputs):
  - a_valid = b_valid = 0; a_data = b_data = 0
  - cnt_a = cnt_b = 0; burst counter = 0
  - pointer state = PT_A; mode_q = 00
  - in_ready = 0 combinationally while reset is high
- Target selection (combinational):
  - mode_q 00: tgt = in_sel
  - mode_q 01 and 10: tgt = pointer (PT_A → 0, PT_B → 1)
  - mode_q 11: no target
- Mode change:
  - mode_q registers cfg_mode every cycle.
  - If cfg_mode != mode_q: in_ready = 0 that cycle; next edge forces pointer to PT_A and burst counter to 0.
- in_ready = !reset && mode_q != 11 && cfg_mode == mode_q && (!tgt_valid || tgt_ready).
  - Pass-through: a full output register that is draining this cycle can accept a new word in the same cycle.
- Accept = in_valid && in_ready.
- On accept:
  - Target register loads in_data and its valid goes to 1. Latency is one cycle: the word appears on x_data at the next edge.
  - The non-target output is untouched.
- Output register holding:
  - x_valid and x_data hold stable while x_valid && !x_ready. No data change and no drop is permitted.
  - x_valid clears on x_ready when no new word is loaded into that output.
- Pointer FSM (states PT_A, PT_B), which advances only on accept:
  - mode 01: toggles on every accept.
  - mode 10: burst counter increments on each accept. When it reaches BURST_LEN-1, the accept toggles the pointer and zeroes the counter.
  - mode 00/11: pointer holds.
- cur_dest = pointer state.
- Counters:
  - On accept, the target's counter increments, saturating at 2^CNT_W-1 with no wrap.
  - cnt_clr: both counters go to 0. If an accept happens in the same cycle, the accepted side's counter becomes 1 and the other becomes 0.
- Downstream stalls:
  - A blocked target (full, not ready) stalls in_ready even if the other output is free.
  - There is no reordering and no bypass to the other destination.
- Hold mode: output registers keep draining normally; no new accepts.

Test Plan:
- Reset with both outputs full and counters at 7 → next cycle: a_valid = b_valid = 0, cnt_a = cnt_b = 0, cur_dest = 0, in_ready = 0 during reset.
- Mode 01, both readies held 1, in_data 0x000001..0x000006 back-to-back → A receives 1,3,5 and B receives 2,4,6, each one cycle after accept; cnt_a = cnt_b = 3; in_ready stays 1 throughout.
- Mode 10, BURST_LEN = 4, ten words 0x100..0x109 → A gets 0x100–0x103, B gets 0x104–0x107, A gets 0x108–0x109; cur_dest = 0 after the tenth accept.
- Mode 00, in_sel = 0, a_ready = 0, stream 0xABCDEF then 0x123456 → first word held stable on a_data; in_ready = 0 until a_ready = 1; the second word is accepted in the same cycle A drains; b_valid stays 0.
- Mode switch from 01 to 10 with pointer at PT_B → in_ready = 0 for one cycle, then the pointer resets to PT_A and the first burst goes to A.
- Preset cnt_a to 0xFFFF and accept to A → stays 0xFFFF; then cnt_clr together with an accept to A → cnt_a = 1, cnt_b = 0.
